inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 213 +++++++++++++++++++++
 tb/tb_inst_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// inst_loader -- UART boot loader for the instruction memory.
//
// Receives 8N1 UART frames on rxd. The first four bytes form a big-endian
// word count N. The next 4*N bytes form N big-endian instruction words, and
// each word is written to consecutive word addresses starting at 0. Words
// whose index falls beyond the memory are consumed but not written. Once the
// last word has been consumed, done rises and stays high until reset.
//
// Ports
//   clk    in   system clock, all state on the rising edge
//   rst    in   asynchronous active-high reset
//   rxd    in   UART receive line (asynchronous to clk, idle high)
//   we     out  one-cycle write strobe per stored word
//   waddr  out  word address of the current write (held between writes)
//   wdata  out  instruction word of the current write (held between writes)
//   busy   out  high from the first header byte until done
//   done   out  image fully loaded
//   err    out  sticky framing-error flag
module inst_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [15:0] BIT_END   = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_END  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [32:0] MEM_WORDS = 33'd1 << ADDR_W;

    // ---- stage p0/p1: rxd synchronizer, resets to idle level ----
    logic rxd_p0, rxd_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_p1 <= rxd_p0;
        end
    end

    // ---- UART receiver ----
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   rx_state, rx_state_nxt;
    logic [15:0] clk_cnt, clk_cnt_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  rx_shift, rx_shift_nxt;
    logic        byte_valid;
    logic        frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            clk_cnt  <= 16'd0;
            bit_cnt  <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_state <= rx_state_nxt;
            clk_cnt  <= clk_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            rx_shift <= rx_shift_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        clk_cnt_nxt  = clk_cnt;
        bit_cnt_nxt  = bit_cnt;
        rx_shift_nxt = rx_shift;
        byte_valid   = 1'b0;
        frame_err    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                clk_cnt_nxt = 16'd0;
                bit_cnt_nxt = 3'd0;
                if (!rxd_p1) rx_state_nxt = RX_START;
            end
            RX_START: begin
                // Re-check the line half a bit in; a high level means the
                // falling edge was a glitch and is dropped silently.
                if (clk_cnt == HALF_END) begin
                    clk_cnt_nxt  = 16'd0;
                    rx_state_nxt = rxd_p1 ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_nxt = clk_cnt + 16'd1;
                end
            end
            RX_DATA: begin
                if (clk_cnt == BIT_END) begin
                    clk_cnt_nxt  = 16'd0;
                    rx_shift_nxt = {rxd_p1, rx_shift[7:1]};
                    if (bit_cnt == 3'd7) rx_state_nxt = RX_STOP;
                    else                 bit_cnt_nxt  = bit_cnt + 3'd1;
                end else begin
                    clk_cnt_nxt = clk_cnt + 16'd1;
                end
            end
            RX_STOP: begin
                // Returning to IDLE at mid stop bit leaves half a bit to
                // catch the next start edge, so back-to-back frames work.
                if (clk_cnt == BIT_END) begin
                    clk_cnt_nxt  = 16'd0;
                    rx_state_nxt = RX_IDLE;
                    if (rxd_p1) byte_valid = 1'b1;
                    else        frame_err  = 1'b1;
                end else begin
                    clk_cnt_nxt = clk_cnt + 16'd1;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // ---- loader ----
    typedef enum logic [1:0] {LD_HDR, LD_BODY, LD_DONE} ld_state_t;

    ld_state_t   ld_state, ld_state_nxt;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_word;
    logic [31:0] word_count;
    logic [31:0] word_idx;
    logic [31:0] full_word;
    logic        last_byte;
    logic        in_range;
    logic        do_write;
    logic        done_set;

    assign full_word = {asm_word, rx_shift};
    assign last_byte = byte_valid && (byte_cnt == 2'd3);
    assign in_range  = {1'b0, word_idx} < MEM_WORDS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ld_state <= LD_HDR;
        else     ld_state <= ld_state_nxt;
    end

    always_comb begin
        ld_state_nxt = ld_state;
        do_write     = 1'b0;
        done_set     = 1'b0;
        case (ld_state)
            LD_HDR: begin
                if (last_byte) begin
                    if (full_word == 32'd0) begin
                        ld_state_nxt = LD_DONE;
                        done_set     = 1'b1;
                    end else begin
                        ld_state_nxt = LD_BODY;
                    end
                end
            end
            LD_BODY: begin
                if (last_byte) begin
                    do_write = in_range;
                    if (word_idx == word_count - 32'd1) ld_state_nxt = LD_DONE;
                end
            end
            LD_DONE: begin
                // Entered from BODY during the final we slot, so done lands
                // one cycle after it.
                done_set = 1'b1;
            end
            default: ld_state_nxt = LD_HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt   <= 2'd0;
            asm_word   <= 24'd0;
            word_count <= 32'd0;
            word_idx   <= 32'd0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            we <= do_write;
            if (do_write) begin
                waddr <= word_idx[ADDR_W-1:0];
                wdata <= full_word;
            end
            // Bad frames never reach here, so a framing error leaves the
            // byte position inside the current word unchanged.
            if (byte_valid && ld_state != LD_DONE) begin
                byte_cnt <= byte_cnt + 2'd1;
                asm_word <= {asm_word[15:0], rx_shift};
            end
            if (ld_state == LD_HDR && last_byte) word_count <= full_word;
            if (ld_state == LD_BODY && last_byte) word_idx <= word_idx + 32'd1;
            if (done_set) begin
                done <= 1'b1;
                busy <= 1'b0;
            end else if (ld_state == LD_HDR && byte_valid) begin
                busy <= 1'b1;
            end
            if (frame_err) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

    localparam int CPB = 8;

    logic        clk;
    logic        rst;
    logic        rxd;

    logic        we_a, busy_a, done_a, err_a;
    logic [9:0]  waddr_a;
    logic [31:0] wdata_a;
    logic        we_b, busy_b, done_b, err_b;
    logic [1:0]  waddr_b;
    logic [31:0] wdata_b;

    inst_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst), .rxd(rxd),
        .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    // Small memory copy fed the same stream, used for the out-of-range case.
    inst_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .rxd(rxd),
        .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor, sampled on the falling edge.
    logic [9:0]  wa_a[$];
    logic [31:0] wd_a[$];
    logic [1:0]  wa_b[$];
    logic [31:0] wd_b[$];
    int unsigned last_we_cyc_a = 0;
    int unsigned done_rise_a   = 0;
    logic        done_a_q      = 1'b0;
    logic        busy_after_done = 1'b0;

    always @(negedge clk) begin
        if (we_a) begin
            wa_a.push_back(waddr_a);
            wd_a.push_back(wdata_a);
            last_we_cyc_a <= cyc;
        end
        if (we_b) begin
            wa_b.push_back(waddr_b);
            wd_b.push_back(wdata_b);
        end
        if (done_a && !done_a_q) done_rise_a <= cyc;
        done_a_q <= done_a;
        if (rst) busy_after_done <= 1'b0;
        else if (done_a && busy_a) busy_after_done <= 1'b1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopv);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stopv);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(4);
    endtask

    task automatic wait_done_a(input string name);
        int k = 0;
        while (!done_a && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, done_a}, 32'd1);
    endtask

    typedef struct {
        int          nbytes;
        logic [95:0] bytes;
        int          exp_n;
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    vec_t vecs[4];
    int   base_a, base_b;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{12, 96'h00000002_24020005_0000000C, 2, 32'h24020005, 32'h0000000C};
        vecs[1] = '{8,  96'h00000001_12345678_00000000, 1, 32'h12345678, 32'h00000000};
        vecs[2] = '{12, 96'h00000002_A55A0FF0_80000001, 2, 32'hA55A0FF0, 32'h80000001};
        vecs[3] = '{4,  96'h00000000_00000000_00000000, 0, 32'h00000000, 32'h00000000};

        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("reset we",    {31'd0, we_a},   32'd0);
        check("reset waddr", {22'd0, waddr_a}, 32'd0);
        check("reset wdata", wdata_a,         32'd0);
        check("reset busy",  {31'd0, busy_a}, 32'd0);
        check("reset done",  {31'd0, done_a}, 32'd0);
        check("reset err",   {31'd0, err_a},  32'd0);
        rst = 1'b0;
        idle(4);

        // ---- table-driven images ----
        for (int v = 0; v < 4; v++) begin
            do_reset();
            base_a = wa_a.size();
            base_b = wa_b.size();
            for (int i = 0; i < vecs[v].nbytes; i++)
                send_byte(vecs[v].bytes[95 - 8*i -: 8], 1'b1);
            idle(8);
            wait_done_a($sformatf("vec%0d done", v));
            check($sformatf("vec%0d write count", v), 32'(wa_a.size() - base_a), 32'(vecs[v].exp_n));
            check($sformatf("vec%0d write count b", v), 32'(wa_b.size() - base_b), 32'(vecs[v].exp_n));
            for (int j = 0; j < vecs[v].exp_n; j++) begin
                if (base_a + j < wa_a.size()) begin
                    check($sformatf("vec%0d waddr%0d", v, j), {22'd0, wa_a[base_a + j]}, 32'(j));
                    check($sformatf("vec%0d wdata%0d", v, j), wd_a[base_a + j],
                          (j == 0) ? vecs[v].d0 : vecs[v].d1);
                end
            end
            if (vecs[v].exp_n > 0) begin
                check($sformatf("vec%0d done after last we", v), done_rise_a - last_we_cyc_a, 32'd1);
                check($sformatf("vec%0d waddr hold", v), {22'd0, waddr_a}, 32'(vecs[v].exp_n - 1));
                check($sformatf("vec%0d wdata hold", v), wdata_a,
                      (vecs[v].exp_n == 1) ? vecs[v].d0 : vecs[v].d1);
            end
            check($sformatf("vec%0d busy", v), {31'd0, busy_a}, 32'd0);
            check($sformatf("vec%0d err", v),  {31'd0, err_a},  32'd0);
        end

        // ---- empty image: done right after the header ----
        do_reset();
        base_a = wa_a.size();
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        check("n0 busy during header", {31'd0, busy_a}, 32'd1);
        check("n0 done early",         {31'd0, done_a}, 32'd0);
        send_byte(8'h00, 1'b1);
        idle(2);
        check("n0 done",        {31'd0, done_a}, 32'd1);
        check("n0 busy",        {31'd0, busy_a}, 32'd0);
        check("n0 no write",    32'(wa_a.size() - base_a), 32'd0);
        check("n0 busy after done", {31'd0, busy_after_done}, 32'd0);

        // ---- short low glitch on an idle line ----
        do_reset();
        base_a = wa_a.size();
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        idle(20);
        check("glitch no byte", {31'd0, busy_a}, 32'd0);
        send_word(32'h00000001);
        send_word(32'hCAFEF00D);
        idle(8);
        wait_done_a("glitch done");
        check("glitch write count", 32'(wa_a.size() - base_a), 32'd1);
        if (wa_a.size() > base_a) begin
            check("glitch waddr", {22'd0, wa_a[base_a]}, 32'd0);
            check("glitch wdata", wd_a[base_a], 32'hCAFEF00D);
        end
        check("glitch err", {31'd0, err_a}, 32'd0);

        // ---- framing error inside word 0 ----
        do_reset();
        base_a = wa_a.size();
        send_word(32'h00000001);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h99, 1'b0);
        idle(2 * CPB);
        check("ferr err set", {31'd0, err_a}, 32'd1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        idle(8);
        wait_done_a("ferr done");
        check("ferr write count", 32'(wa_a.size() - base_a), 32'd1);
        if (wa_a.size() > base_a)
            check("ferr wdata", wd_a[base_a], 32'h11223344);
        check("ferr err sticky", {31'd0, err_a}, 32'd1);

        // ---- asynchronous clear from a loaded state ----
        rst = 1'b1;
        #1;
        check("async rst wdata", wdata_a, 32'd0);
        check("async rst done",  {31'd0, done_a}, 32'd0);
        check("async rst err",   {31'd0, err_a},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(4);

        // ---- reset in the middle of the body ----
        base_a = wa_a.size();
        send_word(32'h00000002);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        check("midrst busy", {31'd0, busy_a}, 32'd1);
        do_reset();
        check("midrst busy cleared", {31'd0, busy_a}, 32'd0);
        send_word(32'h00000001);
        send_word(32'hDEADBEEF);
        idle(8);
        wait_done_a("midrst done");
        check("midrst write count", 32'(wa_a.size() - base_a), 32'd1);
        if (wa_a.size() > base_a) begin
            check("midrst waddr", {22'd0, wa_a[base_a]}, 32'd0);
            check("midrst wdata", wd_a[base_a], 32'hDEADBEEF);
        end

        // ---- more words than the small memory holds ----
        do_reset();
        base_a = wa_a.size();
        base_b = wa_b.size();
        send_word(32'h00000005);
        for (int i = 0; i < 5; i++) send_word(32'hFFFFFFFF);
        idle(8);
        wait_done_a("ovf done a");
        check("ovf done b",        {31'd0, done_b}, 32'd1);
        check("ovf count b",       32'(wa_b.size() - base_b), 32'd4);
        check("ovf count a",       32'(wa_a.size() - base_a), 32'd5);
        for (int j = 0; j < 4; j++) begin
            if (base_b + j < wa_b.size()) begin
                check($sformatf("ovf waddr_b%0d", j), {30'd0, wa_b[base_b + j]}, 32'(j));
                check($sformatf("ovf wdata_b%0d", j), wd_b[base_b + j], 32'hFFFFFFFF);
            end
        end
        check("ovf waddr_b hold", {30'd0, waddr_b}, 32'd3);
        check("ovf waddr_a last", {22'd0, waddr_a}, 32'd4);

        // ---- bytes after done are ignored ----
        send_word(32'h01020304);
        idle(8);
        check("post-done count a", 32'(wa_a.size() - base_a), 32'd5);
        check("post-done done a",  {31'd0, done_a}, 32'd1);
        check("post-done busy a",  {31'd0, busy_a}, 32'd0);
        check("post-done wdata a", wdata_a, 32'hFFFFFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
